// File: rtl/vga_spi_pkg.sv
// Shared definitions for the vga_spi link: command bytes, pixel layout and
// the state encodings of the streamer and its byte shifter.
package vga_spi_pkg;

  localparam logic [7:0] CMD_ALIGN = 8'h80;
  localparam logic [7:0] CMD_SWAP  = 8'h81;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_FETCH,
    ST_PIXEL,
    ST_SWAP,
    ST_DONE
  } streamer_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_GAP
  } tx_state_e;

  // Bit 7 is reserved for commands, so pixel bytes always carry a zero there.
  function automatic logic [7:0] pixel_byte(pixel_t p);
    return {2'b00, p};
  endfunction

endpackage

// File: rtl/vga_spi_streamer_if.sv
// Pixel-memory read port and SPI wires between the streamer, its pixel
// memory and the vga_spi receiver.
interface vga_spi_streamer_if #(
  parameter int unsigned ADDR_WIDTH = 17
) ();

  logic                  pix_rd;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic [5:0]            pix_data;
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;

  modport master (
    output pix_rd, pix_addr, sclk, cs_n, mosi,
    input  pix_data
  );

  modport slave (
    input  pix_rd, pix_addr, sclk, cs_n, mosi,
    output pix_data
  );

endinterface

// File: rtl/spi_byte_tx.sv
// Mode-0 SPI byte shifter: one byte per load pulse, MSB first, with cs_n
// framed per byte and a CS_GAP-clock idle gap before done.
module spi_byte_tx
  import vga_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       done_o,
  output logic       sclk_o,
  output logic       cs_n_o,
  output logic       mosi_o
);

  localparam int unsigned CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CW   = $clog2(CMAX) + 1;

  tx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    half_q;
  logic [7:0]    shreg_q;

  // half_q walks 16 SCLK half-periods plus one trailing low hold before cs_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      shreg_q <= '0;
      done_o  <= 1'b0;
      sclk_o  <= 1'b0;
      cs_n_o  <= 1'b1;
      mosi_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (load_i) begin
            shreg_q <= byte_i;
            mosi_o  <= byte_i[7];
            cs_n_o  <= 1'b0;
            cnt_q   <= '0;
            half_q  <= '0;
            state_q <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (cnt_q == CW'(CLK_DIV - 1)) begin
            cnt_q <= '0;
            if (half_q == 5'd16) begin
              cs_n_o  <= 1'b1;
              state_q <= TX_GAP;
            end else begin
              half_q <= half_q + 5'd1;
              sclk_o <= ~sclk_o;
              if (sclk_o) begin
                shreg_q <= {shreg_q[6:0], 1'b0};
                mosi_o  <= shreg_q[6];
              end
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        TX_GAP: begin
          if (cnt_q == CW'(CS_GAP - 1)) begin
            cnt_q   <= '0;
            done_o  <= 1'b1;
            state_q <= TX_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vga_spi_streamer.sv
// Frame sequencer: ALIGN, one fetched pixel byte per framebuffer address in
// raster order, then SWAP, all serialised through spi_byte_tx.
module vga_spi_streamer
  import vga_spi_pkg::*;
#(
  parameter int unsigned RES_X      = 320,
  parameter int unsigned RES_Y      = 240,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned CS_GAP     = 4,
  parameter int unsigned ADDR_WIDTH = $clog2(RES_X * RES_Y)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                frame_done,
  vga_spi_streamer_if.master  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RES_X * RES_Y - 1);

  streamer_state_e       state_q;
  logic                  sent_q;
  logic                  load_q;
  logic [7:0]            tx_byte_q;
  logic                  pix_rd_q;
  logic [ADDR_WIDTH-1:0] pix_addr_q;
  logic                  tx_done;

  assign bus.pix_rd   = pix_rd_q;
  assign bus.pix_addr = pix_addr_q;

  // Each sending state spends its first cycle raising load (sent_q marks it)
  // and then waits for done; pix_rd is raised on entry to FETCH, so the data
  // is captured on FETCH's second cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sent_q     <= 1'b0;
      load_q     <= 1'b0;
      tx_byte_q  <= '0;
      pix_rd_q   <= 1'b0;
      pix_addr_q <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      load_q     <= 1'b0;
      pix_rd_q   <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            pix_addr_q <= '0;
            sent_q     <= 1'b0;
            state_q    <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (!sent_q) begin
            load_q    <= 1'b1;
            tx_byte_q <= CMD_ALIGN;
            sent_q    <= 1'b1;
          end else if (tx_done) begin
            sent_q   <= 1'b0;
            pix_rd_q <= 1'b1;
            state_q  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!pix_rd_q) begin
            tx_byte_q <= pixel_byte(pixel_t'(bus.pix_data));
            state_q   <= ST_PIXEL;
          end
        end
        ST_PIXEL: begin
          if (!sent_q) begin
            load_q <= 1'b1;
            sent_q <= 1'b1;
          end else if (tx_done) begin
            sent_q <= 1'b0;
            if (pix_addr_q == LAST_ADDR) begin
              state_q <= ST_SWAP;
            end else begin
              pix_addr_q <= pix_addr_q + ADDR_WIDTH'(1);
              pix_rd_q   <= 1'b1;
              state_q    <= ST_FETCH;
            end
          end
        end
        ST_SWAP: begin
          if (!sent_q) begin
            load_q    <= 1'b1;
            tx_byte_q <= CMD_SWAP;
            sent_q    <= 1'b1;
          end else if (tx_done) begin
            sent_q     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  spi_byte_tx #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load_q),
    .byte_i (tx_byte_q),
    .done_o (tx_done),
    .sclk_o (bus.sclk),
    .cs_n_o (bus.cs_n),
    .mosi_o (bus.mosi)
  );

endmodule
